// File: rtl/memory_access_pkg.sv
// -----------------------------------------------------------------------------
// memory_access_pkg
// Shared definitions for the RV64 memory stage: access-width and branch-op
// encodings, the bus-access FSM state type, and lane helper functions used by
// the top level to build byte masks and detect misaligned accesses.
// -----------------------------------------------------------------------------
package memory_access_pkg;

    localparam logic [2:0] MEM_WIDTH_B = 3'd0;
    localparam logic [2:0] MEM_WIDTH_H = 3'd1;
    localparam logic [2:0] MEM_WIDTH_W = 3'd2;
    localparam logic [2:0] MEM_WIDTH_D = 3'd3;

    localparam logic [2:0] BRANCH_OP_NONE     = 3'd0;
    localparam logic [2:0] BRANCH_OP_ALWAYS   = 3'd1;
    localparam logic [2:0] BRANCH_OP_ZERO     = 3'd2;
    localparam logic [2:0] BRANCH_OP_NON_ZERO = 3'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Byte-lane enables for a store. A doubleword always covers all eight
    // lanes; narrower accesses are shifted up, and lanes past 7 fall off.
    function automatic logic [7:0] lane_mask(input logic [2:0] width,
                                             input logic [2:0] offset);
        logic [7:0] base;
        case (width)
            MEM_WIDTH_B: base = 8'h01;
            MEM_WIDTH_H: base = 8'h03;
            MEM_WIDTH_W: base = 8'h0F;
            default:     base = 8'hFF;
        endcase
        return (base == 8'hFF) ? base : (base << offset);
    endfunction

    // True when the byte offset is not a multiple of the access size.
    function automatic logic is_misaligned(input logic [2:0] width,
                                           input logic [2:0] offset);
        logic mis;
        case (width)
            MEM_WIDTH_B: mis = 1'b0;
            MEM_WIDTH_H: mis = offset[0];
            MEM_WIDTH_W: mis = |offset[1:0];
            default:     mis = |offset;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/memory_access_load_align.sv
// -----------------------------------------------------------------------------
// memory_access_load_align
// Combinational load aligner: shifts the addressed bytes of a 64-bit bus word
// down to bit 0, truncates to the access width and sign/zero-extends to 64.
// Ports:
//   offset_in       byte offset within the doubleword
//   width_in        0=B 1=H 2=W 3=D
//   zero_extend_in  1 = zero-extend, 0 = sign-extend
//   raw_in          raw bus read data
//   value_out       aligned, extended load value
// -----------------------------------------------------------------------------
module memory_access_load_align
    import memory_access_pkg::*;
(
    input  logic [2:0]  offset_in,
    input  logic [2:0]  width_in,
    input  logic        zero_extend_in,
    input  logic [63:0] raw_in,
    output logic [63:0] value_out
);

    logic [63:0] shifted;

    assign shifted = raw_in >> {offset_in, 3'b000};

    always_comb begin
        value_out = shifted;
        case (width_in)
            MEM_WIDTH_B: value_out = zero_extend_in ? {56'd0, shifted[7:0]}
                                                    : {{56{shifted[7]}}, shifted[7:0]};
            MEM_WIDTH_H: value_out = zero_extend_in ? {48'd0, shifted[15:0]}
                                                    : {{48{shifted[15]}}, shifted[15:0]};
            MEM_WIDTH_W: value_out = zero_extend_in ? {32'd0, shifted[31:0]}
                                                    : {{32{shifted[31]}}, shifted[31:0]};
            default:     value_out = shifted;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// -----------------------------------------------------------------------------
// memory_access
// Memory stage of the 5-stage RV64 pipeline. Issues loads/stores on a 64-bit
// req/ready bus, aligns load data, resolves branches and drives the writeback
// register. While a bus access is outstanding stall_out holds the pipeline.
// Optional feature macro: MEMORY_ACCESS_MISALIGN_TRAP_EN (adds misaligned_out;
// misaligned accesses are suppressed instead of performed on in-range lanes).
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   stall_in                   downstream hold (output registers keep value)
//   valid_in .. next_pc_in     execute-stage output register fields
//   bus_*                      data bus request / response
//   stall_out                  pipeline hold request
//   branch_mispredicted_out    redirect fetch, flush younger stages
//   branch_pc_out              redirect target
//   fence_out                  one-cycle FENCE pulse
//   valid_out, rd_*_out        writeback register
// -----------------------------------------------------------------------------
module memory_access
    import memory_access_pkg::*;
#(
    parameter logic [63:0] RESET_VECTOR = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        valid_in,
    input  logic        branch_predicted_taken_in,
    input  logic        alu_non_zero_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [2:0]  mem_width_in,
    input  logic        mem_zero_extend_in,
    input  logic        mem_fence_in,
    input  logic [2:0]  branch_op_in,
    input  logic [8:0]  rd_in,
    input  logic        rd_write_in,
    input  logic [63:0] result_in,
    input  logic [63:0] rs2_value_in,
    input  logic [63:0] branch_pc_in,
    input  logic [63:0] next_pc_in,
    output logic [63:0] bus_address_out,
    output logic        bus_read_out,
    output logic        bus_write_out,
    output logic [7:0]  bus_write_mask_out,
    output logic [63:0] bus_write_value_out,
    input  logic [63:0] bus_read_value_in,
    input  logic        bus_ready_in,
    output logic        stall_out,
    output logic        branch_mispredicted_out,
    output logic [63:0] branch_pc_out,
    output logic        fence_out,
`ifdef MEMORY_ACCESS_MISALIGN_TRAP_EN
    output logic        misaligned_out,
`endif
    output logic        valid_out,
    output logic [8:0]  rd_out,
    output logic        rd_write_out,
    output logic [63:0] rd_value_out
);

    // ---------------- state ----------------
    state_t      state_q, state_d;
    logic [63:0] addr_lat_q, addr_lat_d;
    logic        read_lat_q, read_lat_d;
    logic        write_lat_q, write_lat_d;
    logic [7:0]  mask_lat_q, mask_lat_d;
    logic [63:0] wdata_lat_q, wdata_lat_d;
    logic [2:0]  off_lat_q, off_lat_d;
    logic [2:0]  width_lat_q, width_lat_d;
    logic        zext_lat_q, zext_lat_d;
    // Response that arrived while stall_in was high, parked until it drops.
    logic        have_data_q, have_data_d;
    logic [63:0] rdata_q, rdata_d;

    logic        valid_q, valid_d;
    logic [8:0]  rd_q, rd_d;
    logic        rd_write_q, rd_write_d;
    logic [63:0] rd_value_q, rd_value_d;
    logic        fence_q, fence_d;
    logic        mis_q, mis_d;
    logic [63:0] branch_pc_q, branch_pc_d;

    // ---------------- decode ----------------
    logic [2:0]  offset;
    logic        is_mem;
    logic        misaligned;
    logic        misaligned_acc;
    logic        req_idle;
    logic        taken;
    logic [63:0] branch_target;
    logic        update;

    logic [2:0]  align_off;
    logic [2:0]  align_width;
    logic        align_zext;
    logic [63:0] align_raw;
    logic        load_sel;
    logic [63:0] load_value;

    assign offset = result_in[2:0];
    assign is_mem = mem_read_in | mem_write_in;

`ifdef MEMORY_ACCESS_MISALIGN_TRAP_EN
    assign misaligned = is_misaligned(mem_width_in, offset);
`else
    assign misaligned = 1'b0;
`endif

    // Misalignment only matters for a fresh access seen in IDLE.
    assign misaligned_acc = (state_q == ST_IDLE) & valid_in & is_mem & misaligned;
    // A fresh request waits for stall_in to drop so read data cannot be lost.
    assign req_idle = valid_in & is_mem & ~misaligned & ~stall_in;

    assign taken = (branch_op_in == BRANCH_OP_ALWAYS)
                 | ((branch_op_in == BRANCH_OP_ZERO)     & ~alu_non_zero_in)
                 | ((branch_op_in == BRANCH_OP_NON_ZERO) &  alu_non_zero_in);
    assign branch_target = taken ? branch_pc_in : next_pc_in;

    // ---------------- bus FSM ----------------
    always_comb begin
        state_d     = state_q;
        addr_lat_d  = addr_lat_q;
        read_lat_d  = read_lat_q;
        write_lat_d = write_lat_q;
        mask_lat_d  = mask_lat_q;
        wdata_lat_d = wdata_lat_q;
        off_lat_d   = off_lat_q;
        width_lat_d = width_lat_q;
        zext_lat_d  = zext_lat_q;
        have_data_d = have_data_q;
        rdata_d     = rdata_q;

        bus_address_out     = {result_in[63:3], 3'b000};
        bus_read_out        = 1'b0;
        bus_write_out       = 1'b0;
        bus_write_mask_out  = 8'h00;
        bus_write_value_out = rs2_value_in << {offset, 3'b000};
        stall_out           = 1'b0;

        align_off   = offset;
        align_width = mem_width_in;
        align_zext  = mem_zero_extend_in;
        align_raw   = bus_read_value_in;
        load_sel    = mem_read_in;

        if (reset) begin
            // Keep the bus and stall quiet while the registers clear.
        end else if (state_q == ST_IDLE) begin
            bus_read_out       = req_idle & mem_read_in;
            bus_write_out      = req_idle & mem_write_in;
            bus_write_mask_out = (req_idle & mem_write_in) ? lane_mask(mem_width_in, offset) : 8'h00;
            if (req_idle && !bus_ready_in) begin
                stall_out   = 1'b1;
                state_d     = ST_WAIT;
                addr_lat_d  = {result_in[63:3], 3'b000};
                read_lat_d  = mem_read_in;
                write_lat_d = mem_write_in;
                mask_lat_d  = mem_write_in ? lane_mask(mem_width_in, offset) : 8'h00;
                wdata_lat_d = rs2_value_in << {offset, 3'b000};
                off_lat_d   = offset;
                width_lat_d = mem_width_in;
                zext_lat_d  = mem_zero_extend_in;
            end
        end else begin
            // Drive the bus from the latched copy so it stays stable.
            bus_address_out     = addr_lat_q;
            bus_read_out        = read_lat_q & ~have_data_q;
            bus_write_out       = write_lat_q & ~have_data_q;
            bus_write_mask_out  = have_data_q ? 8'h00 : mask_lat_q;
            bus_write_value_out = wdata_lat_q;
            align_off   = off_lat_q;
            align_width = width_lat_q;
            align_zext  = zext_lat_q;
            align_raw   = have_data_q ? rdata_q : bus_read_value_in;
            load_sel    = read_lat_q;
            if (have_data_q) begin
                if (!stall_in) begin
                    state_d     = ST_IDLE;
                    have_data_d = 1'b0;
                end
            end else if (bus_ready_in) begin
                if (stall_in) begin
                    have_data_d = 1'b1;
                    rdata_d     = bus_read_value_in;
                end else begin
                    state_d = ST_IDLE;
                end
            end else begin
                stall_out = 1'b1;
            end
        end
    end

    memory_access_load_align u_load_align (
        .offset_in      (align_off),
        .width_in       (align_width),
        .zero_extend_in (align_zext),
        .raw_in         (align_raw),
        .value_out      (load_value)
    );

    // ---------------- writeback register ----------------
    assign update = ~stall_in & ~stall_out;

    always_comb begin
        valid_d     = valid_q;
        rd_d        = rd_q;
        rd_write_d  = rd_write_q;
        rd_value_d  = rd_value_q;
        fence_d     = 1'b0;
        mis_d       = 1'b0;
        branch_pc_d = branch_pc_q;
        if (update) begin
            valid_d    = valid_in & ~misaligned_acc;
            rd_d       = rd_in;
            rd_write_d = valid_in & rd_write_in & ~misaligned_acc;
            rd_value_d = load_sel ? load_value : result_in;
            fence_d    = valid_in & mem_fence_in;
            mis_d      = misaligned_acc;
            if (valid_in && branch_op_in != BRANCH_OP_NONE) begin
                branch_pc_d = branch_target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_lat_q  <= 64'd0;
            read_lat_q  <= 1'b0;
            write_lat_q <= 1'b0;
            mask_lat_q  <= 8'h00;
            wdata_lat_q <= 64'd0;
            off_lat_q   <= 3'd0;
            width_lat_q <= 3'd0;
            zext_lat_q  <= 1'b0;
            have_data_q <= 1'b0;
            rdata_q     <= 64'd0;
            valid_q     <= 1'b0;
            rd_q        <= 9'd0;
            rd_write_q  <= 1'b0;
            rd_value_q  <= 64'd0;
            fence_q     <= 1'b0;
            mis_q       <= 1'b0;
            branch_pc_q <= RESET_VECTOR;
        end else begin
            state_q     <= state_d;
            addr_lat_q  <= addr_lat_d;
            read_lat_q  <= read_lat_d;
            write_lat_q <= write_lat_d;
            mask_lat_q  <= mask_lat_d;
            wdata_lat_q <= wdata_lat_d;
            off_lat_q   <= off_lat_d;
            width_lat_q <= width_lat_d;
            zext_lat_q  <= zext_lat_d;
            have_data_q <= have_data_d;
            rdata_q     <= rdata_d;
            valid_q     <= valid_d;
            rd_q        <= rd_d;
            rd_write_q  <= rd_write_d;
            rd_value_q  <= rd_value_d;
            fence_q     <= fence_d;
            mis_q       <= mis_d;
            branch_pc_q <= branch_pc_d;
        end
    end

    // ---------------- outputs ----------------
    // Redirect target is live for a branch in this stage, else the last one.
    assign branch_mispredicted_out = ~reset & valid_in & ~stall_out
                                   & (branch_op_in != BRANCH_OP_NONE)
                                   & (taken != branch_predicted_taken_in);
    assign branch_pc_out = (~reset && valid_in && branch_op_in != BRANCH_OP_NONE)
                         ? branch_target : branch_pc_q;

    assign valid_out    = valid_q;
    assign rd_out       = rd_q;
    assign rd_write_out = rd_write_q;
    assign rd_value_out = rd_value_q;
    assign fence_out    = fence_q;

`ifdef MEMORY_ACCESS_MISALIGN_TRAP_EN
    assign misaligned_out = mis_q;
`else
    // Without the trap there is no misalignment report; mis_q stays low.
    logic unused_mis;
    assign unused_mis = mis_q;
`endif

endmodule

// File: tb/tb_memory_access.sv
// -----------------------------------------------------------------------------
// tb_memory_access
// Directed self-checking bench for memory_access: reset state, zero-wait and
// sign/zero-extended loads, a store with wait states, branch resolution,
// downstream stall, FENCE pulse and reset during an outstanding access.
// -----------------------------------------------------------------------------
module tb_memory_access;

    localparam logic [63:0] RV = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        reset, stall_in, valid_in, branch_predicted_taken_in, alu_non_zero_in;
    logic        mem_read_in, mem_write_in, mem_zero_extend_in, mem_fence_in, rd_write_in;
    logic [2:0]  mem_width_in, branch_op_in;
    logic [8:0]  rd_in;
    logic [63:0] result_in, rs2_value_in, branch_pc_in, next_pc_in, bus_read_value_in;
    logic        bus_ready_in;
    logic [63:0] bus_address_out, bus_write_value_out, branch_pc_out, rd_value_out;
    logic        bus_read_out, bus_write_out, stall_out, branch_mispredicted_out;
    logic        fence_out, valid_out, rd_write_out;
    logic [7:0]  bus_write_mask_out;
    logic [8:0]  rd_out;
`ifdef MEMORY_ACCESS_MISALIGN_TRAP_EN
    logic        misaligned_out;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory_access #(.RESET_VECTOR(RV)) dut (
        .clk(clk), .reset(reset), .stall_in(stall_in), .valid_in(valid_in),
        .branch_predicted_taken_in(branch_predicted_taken_in), .alu_non_zero_in(alu_non_zero_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .mem_width_in(mem_width_in),
        .mem_zero_extend_in(mem_zero_extend_in), .mem_fence_in(mem_fence_in),
        .branch_op_in(branch_op_in), .rd_in(rd_in), .rd_write_in(rd_write_in),
        .result_in(result_in), .rs2_value_in(rs2_value_in), .branch_pc_in(branch_pc_in),
        .next_pc_in(next_pc_in), .bus_address_out(bus_address_out), .bus_read_out(bus_read_out),
        .bus_write_out(bus_write_out), .bus_write_mask_out(bus_write_mask_out),
        .bus_write_value_out(bus_write_value_out), .bus_read_value_in(bus_read_value_in),
        .bus_ready_in(bus_ready_in), .stall_out(stall_out),
        .branch_mispredicted_out(branch_mispredicted_out), .branch_pc_out(branch_pc_out),
        .fence_out(fence_out),
`ifdef MEMORY_ACCESS_MISALIGN_TRAP_EN
        .misaligned_out(misaligned_out),
`endif
        .valid_out(valid_out), .rd_out(rd_out), .rd_write_out(rd_write_out),
        .rd_value_out(rd_value_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall_in = 0; valid_in = 0; branch_predicted_taken_in = 0; alu_non_zero_in = 0;
        mem_read_in = 0; mem_write_in = 0; mem_width_in = 3'd0; mem_zero_extend_in = 0;
        mem_fence_in = 0; branch_op_in = 3'd0; rd_in = 9'd0; rd_write_in = 0;
        result_in = 64'd0; rs2_value_in = 64'd0; branch_pc_in = 64'd0; next_pc_in = 64'd0;
        bus_read_value_in = 64'd0; bus_ready_in = 0;
    endtask

    task automatic load(input logic [63:0] addr, input logic [2:0] w, input logic zx,
                        input logic [63:0] data, input logic rdy);
        idle_inputs();
        valid_in = 1; mem_read_in = 1; mem_width_in = w; mem_zero_extend_in = zx;
        result_in = addr; bus_read_value_in = data; bus_ready_in = rdy; rd_in = 9'd5; rd_write_in = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        step(); step();
        reset = 0;
        #3;
        $display("txn reset");
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", valid_out); end
        checks++; if (rd_write_out !== 1'b0) begin errors++; $display("FAIL reset_rd_write got %0h exp 0", rd_write_out); end
        checks++; if (rd_out !== 9'd0) begin errors++; $display("FAIL reset_rd got %0h exp 0", rd_out); end
        checks++; if (rd_value_out !== 64'd0) begin errors++; $display("FAIL reset_rd_value got %h exp 0", rd_value_out); end
        checks++; if (fence_out !== 1'b0) begin errors++; $display("FAIL reset_fence got %0h exp 0", fence_out); end
        checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall got %0h exp 0", stall_out); end
        checks++; if (branch_pc_out !== RV) begin errors++; $display("FAIL reset_branch_pc got %h exp %h", branch_pc_out, RV); end
        checks++; if ({bus_read_out, bus_write_out} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b exp 00", {bus_read_out, bus_write_out}); end
    endtask

    task automatic test_load_zero_wait();
        load(64'h1000, 3'd3, 0, 64'h1122_3344_5566_7788, 1);
        #3;
        $display("txn ld addr=1000 zero-wait");
        checks++; if (bus_read_out !== 1'b1) begin errors++; $display("FAIL ld_read_strobe got %0h exp 1", bus_read_out); end
        checks++; if (bus_address_out !== 64'h1000) begin errors++; $display("FAIL ld_addr got %h exp 1000", bus_address_out); end
        checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL ld_stall got %0h exp 0", stall_out); end
        step();
        checks++; if (rd_value_out !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL ld_value got %h exp 1122334455667788", rd_value_out); end
        checks++; if ({valid_out, rd_write_out, rd_out} !== {1'b1, 1'b1, 9'd5}) begin errors++; $display("FAIL ld_wb got %0h/%0h/%0h exp 1/1/5", valid_out, rd_write_out, rd_out); end
        idle_inputs(); step();
    endtask

    task automatic test_load_extend();
        load(64'h1003, 3'd0, 0, 64'h0000_0000_8000_0000, 1);
        #3;
        $display("txn lb addr=1003");
        checks++; if (bus_address_out !== 64'h1000) begin errors++; $display("FAIL lb_addr got %h exp 1000", bus_address_out); end
        step();
        checks++; if (rd_value_out !== 64'hFFFF_FFFF_FFFF_FF80) begin errors++; $display("FAIL lb_sign got %h exp ffffffffffffff80", rd_value_out); end
        load(64'h1003, 3'd0, 1, 64'h0000_0000_8000_0000, 1);
        step();
        $display("txn lbu addr=1003");
        checks++; if (rd_value_out !== 64'h80) begin errors++; $display("FAIL lbu_zero got %h exp 80", rd_value_out); end
        load(64'h1004, 3'd2, 0, 64'h8765_4321_0000_0000, 1);
        step();
        $display("txn lw addr=1004");
        checks++; if (rd_value_out !== 64'hFFFF_FFFF_8765_4321) begin errors++; $display("FAIL lw_sign got %h exp ffffffff87654321", rd_value_out); end
        load(64'h1002, 3'd1, 1, 64'h0000_0000_BEEF_0000, 1);
        step();
        $display("txn lhu addr=1002");
        checks++; if (rd_value_out !== 64'hBEEF) begin errors++; $display("FAIL lhu_zero got %h exp beef", rd_value_out); end
        idle_inputs(); step();
    endtask

    task automatic test_store_wait();
        int stalls = 0;
        idle_inputs();
        valid_in = 1; mem_write_in = 1; mem_width_in = 3'd1; result_in = 64'h2006; rs2_value_in = 64'hABCD;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) bus_ready_in = 1;
            #3;
            $display("txn sh addr=2006 cycle %0d stall=%0d", c, stall_out);
            if (stall_out === 1'b1) stalls++;
            checks++; if (bus_write_out !== 1'b1) begin errors++; $display("FAIL sh_strobe c%0d got %0h exp 1", c, bus_write_out); end
            checks++; if (bus_write_mask_out !== 8'hC0) begin errors++; $display("FAIL sh_mask c%0d got %h exp c0", c, bus_write_mask_out); end
            checks++; if (bus_write_value_out !== 64'hABCD_0000_0000_0000) begin errors++; $display("FAIL sh_data c%0d got %h exp abcd000000000000", c, bus_write_value_out); end
            checks++; if (bus_address_out !== 64'h2000) begin errors++; $display("FAIL sh_addr c%0d got %h exp 2000", c, bus_address_out); end
            if (c == 1) begin
                checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL sh_hold_valid got %0h exp 0", valid_out); end
            end
            step();
            // Upstream contents change while waiting; the bus must not follow.
            result_in = 64'h3000; rs2_value_in = 64'd0;
        end
        checks++; if (stalls != 3) begin errors++; $display("FAIL sh_stall_cycles got %0d exp 3", stalls); end
        checks++; if ({valid_out, rd_write_out} !== 2'b10) begin errors++; $display("FAIL sh_wb got %b exp 10", {valid_out, rd_write_out}); end
        idle_inputs();
        #3;
        checks++; if (bus_write_out !== 1'b0 || stall_out !== 1'b0) begin errors++; $display("FAIL sh_release got %0h/%0h exp 0/0", bus_write_out, stall_out); end
        step();
    endtask

    task automatic test_branch();
        idle_inputs();
        valid_in = 1; branch_op_in = 3'd3; alu_non_zero_in = 1; branch_predicted_taken_in = 0;
        branch_pc_in = 64'h400; next_pc_in = 64'h104;
        #3;
        $display("txn bne nz=1 pred=0");
        checks++; if (branch_mispredicted_out !== 1'b1) begin errors++; $display("FAIL bne_mispred got %0h exp 1", branch_mispredicted_out); end
        checks++; if (branch_pc_out !== 64'h400) begin errors++; $display("FAIL bne_pc got %h exp 400", branch_pc_out); end
        step();
        branch_op_in = 3'd2; branch_predicted_taken_in = 1;
        #3;
        $display("txn beq nz=1 pred=1");
        checks++; if (branch_mispredicted_out !== 1'b1) begin errors++; $display("FAIL beq_mispred got %0h exp 1", branch_mispredicted_out); end
        checks++; if (branch_pc_out !== 64'h104) begin errors++; $display("FAIL beq_pc got %h exp 104", branch_pc_out); end
        step();
        branch_op_in = 3'd1; branch_predicted_taken_in = 1; rd_in = 9'd1; rd_write_in = 1; result_in = 64'h108;
        #3;
        $display("txn jal pred=1");
        checks++; if (branch_mispredicted_out !== 1'b0) begin errors++; $display("FAIL jal_mispred got %0h exp 0", branch_mispredicted_out); end
        step();
        checks++; if ({rd_write_out, rd_out, rd_value_out} !== {1'b1, 9'd1, 64'h108}) begin errors++; $display("FAIL jal_link got %0h/%0h/%h exp 1/1/108", rd_write_out, rd_out, rd_value_out); end
        valid_in = 0; branch_op_in = 3'd3; branch_predicted_taken_in = 0; rd_write_in = 0;
        #3;
        $display("txn bne invalid");
        checks++; if (branch_mispredicted_out !== 1'b0) begin errors++; $display("FAIL invalid_mispred got %0h exp 0", branch_mispredicted_out); end
        step();
        checks++; if ({valid_out, rd_write_out} !== 2'b00) begin errors++; $display("FAIL invalid_wb got %b exp 00", {valid_out, rd_write_out}); end
        idle_inputs(); step();
    endtask

    task automatic test_stall_in();
        idle_inputs();
        valid_in = 1; rd_in = 9'd7; rd_write_in = 1; result_in = 64'h77;
        step();
        $display("txn alu rd=7");
        checks++; if (rd_value_out !== 64'h77) begin errors++; $display("FAIL alu_value got %h exp 77", rd_value_out); end
        load(64'h1008, 3'd3, 0, 64'hCAFE_BABE_DEAD_BEEF, 1);
        stall_in = 1;
        #3;
        $display("txn ld under stall_in");
        checks++; if (bus_read_out !== 1'b0 || stall_out !== 1'b0) begin errors++; $display("FAIL stall_in_req got %0h/%0h exp 0/0", bus_read_out, stall_out); end
        step();
        checks++; if (rd_value_out !== 64'h77) begin errors++; $display("FAIL stall_in_hold got %h exp 77", rd_value_out); end
        stall_in = 0;
        #3;
        checks++; if (bus_read_out !== 1'b1) begin errors++; $display("FAIL stall_release_req got %0h exp 1", bus_read_out); end
        step();
        checks++; if (rd_value_out !== 64'hCAFE_BABE_DEAD_BEEF) begin errors++; $display("FAIL stall_release_value got %h exp cafebabedeadbeef", rd_value_out); end
        idle_inputs(); step();
    endtask

    task automatic test_fence();
        idle_inputs();
        valid_in = 1; mem_fence_in = 1;
        step();
        $display("txn fence");
        checks++; if (fence_out !== 1'b1) begin errors++; $display("FAIL fence_pulse got %0h exp 1", fence_out); end
        idle_inputs(); step();
        checks++; if (fence_out !== 1'b0) begin errors++; $display("FAIL fence_clear got %0h exp 0", fence_out); end
    endtask

    task automatic test_reset_in_wait();
        load(64'h1010, 3'd3, 0, 64'h55, 0);
        #3;
        checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL rw_stall_idle got %0h exp 1", stall_out); end
        step();
        #3;
        checks++; if (bus_read_out !== 1'b1 || stall_out !== 1'b1) begin errors++; $display("FAIL rw_wait got %0h/%0h exp 1/1", bus_read_out, stall_out); end
        reset = 1;
        step();
        reset = 0;
        idle_inputs();
        #3;
        $display("txn reset during wait");
        checks++; if ({bus_read_out, bus_write_out, stall_out, valid_out} !== 4'b0000) begin errors++; $display("FAIL rw_after got %b exp 0000", {bus_read_out, bus_write_out, stall_out, valid_out}); end
        load(64'h1018, 3'd3, 0, 64'h1234, 1);
        step();
        checks++; if (rd_value_out !== 64'h1234) begin errors++; $display("FAIL rw_recover got %h exp 1234", rd_value_out); end
        idle_inputs(); step();
    endtask

    initial begin
        test_reset();
        test_load_zero_wait();
        test_load_extend();
        test_store_wait();
        test_branch();
        test_stall_in();
        test_fence();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
